// File: rtl/float2fixed_arbiter_if.sv
// Bus bundle between the arbiter, its requesters, the shared converter and the result consumer.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface float2fixed_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]    req_i;
    logic [NUM_REQ*16-1:0] float_in;
    logic [NUM_REQ-1:0]    gnt_o;
    logic [15:0]           conv_float_o;
    logic                  conv_valid_o;
    logic [47:0]           conv_fixed_i;
    logic [47:0]           fixed_out;
    logic [ID_W-1:0]       out_id;
    logic                  out_valid;
    logic                  out_ready;

    modport slave (
        input  req_i, float_in, conv_fixed_i, out_ready,
        output gnt_o, conv_float_o, conv_valid_o, fixed_out, out_id, out_valid
    );

    modport master (
        output req_i, float_in, conv_fixed_i, out_ready,
        input  gnt_o, conv_float_o, conv_valid_o, fixed_out, out_id, out_valid
    );
endinterface

// File: rtl/float2fixed_arbiter.sv
// Round-robin sharing of one non-stallable fp16->fixed converter among NUM_REQ requesters.
// Each result is tagged with its requester id and queued in a credit-protected output FIFO.
module float2fixed_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int CONV_LAT   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    float2fixed_arbiter_if.slave bus
);
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PEND_W = $clog2(FIFO_DEPTH + CONV_LAT + 2) + 1;
    localparam int ENT_W  = ID_W + 48;

    logic [ID_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_any;
    logic [15:0]        sel_float;
    int                 search_idx;

    logic               conv_valid;
    logic [15:0]        conv_float;
    logic [ID_W-1:0]    conv_id;

    logic [CONV_LAT-1:0] tag_valid;
    logic [ID_W-1:0]     tag_id [CONV_LAT];

    logic [ENT_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENT_W-1:0]   head;
    logic               push;
    logic               pop;
    logic [PEND_W-1:0]  pending;

    // Every conversion that has been issued but not yet popped holds one FIFO credit.
    always_comb begin
        pending = PEND_W'(fifo_count) + PEND_W'(conv_valid);
        for (int i = 0; i < CONV_LAT; i++) begin
            pending = pending + PEND_W'(tag_valid[i]);
        end
    end

    always_comb begin
        gnt        = '0;
        gnt_id     = '0;
        gnt_any    = 1'b0;
        sel_float  = '0;
        search_idx = 0;
        if (!reset && (pending < PEND_W'(FIFO_DEPTH))) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                search_idx = int'(rr_ptr) + i;
                if (search_idx >= NUM_REQ) begin
                    search_idx = search_idx - NUM_REQ;
                end
                if (!gnt_any && bus.req_i[search_idx]) begin
                    gnt[search_idx] = 1'b1;
                    gnt_id          = ID_W'(search_idx);
                    sel_float       = bus.float_in[search_idx*16 +: 16];
                    gnt_any         = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conv_valid <= 1'b0;
            conv_float <= '0;
            conv_id    <= '0;
            rr_ptr     <= '0;
        end else begin
            conv_valid <= gnt_any;
            if (gnt_any) begin
                conv_float <= sel_float;
                conv_id    <= gnt_id;
                rr_ptr     <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
            end
        end
    end

    // The tag pipe mirrors the converter latency so each result is matched to its requester.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_valid <= '0;
            for (int i = 0; i < CONV_LAT; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            tag_valid[0] <= conv_valid;
            tag_id[0]    <= conv_id;
            for (int i = 1; i < CONV_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
            end
        end
    end

    assign push = tag_valid[CONV_LAT-1];
    assign pop  = (fifo_count != '0) && bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {tag_id[CONV_LAT-1], bus.conv_fixed_i};
                wr_ptr           <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign head             = fifo_mem[rd_ptr];
    assign bus.gnt_o        = gnt;
    assign bus.conv_valid_o = conv_valid;
    assign bus.conv_float_o = conv_float;
    assign bus.fixed_out    = head[47:0];
    assign bus.out_id       = head[ENT_W-1:48];
    assign bus.out_valid    = (fifo_count != '0);
endmodule

// File: tb/tb_float2fixed_arbiter.sv
// Directed bench for float2fixed_arbiter with a pass-through converter model
// (conv_fixed_i = {32'h0, conv_float_o} delayed CONV_LAT cycles).
module tb_float2fixed_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int CONV_LAT   = 2;
    localparam int FIFO_DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int           grant_log [$];
    logic [49:0]  pop_log [$];
    logic [15:0]  conv_pipe [CONV_LAT];

    float2fixed_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    float2fixed_arbiter #(
        .NUM_REQ(NUM_REQ),
        .CONV_LAT(CONV_LAT),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        conv_pipe[0] <= bus.conv_float_o;
        for (int i = 1; i < CONV_LAT; i++) begin
            conv_pipe[i] <= conv_pipe[i-1];
        end
    end
    assign bus.conv_fixed_i = {32'h0, conv_pipe[CONV_LAT-1]};

    task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Transfers and pops are logged mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (bus.gnt_o[k] && bus.req_i[k]) grant_log.push_back(k);
            end
            if (bus.out_valid && bus.out_ready) pop_log.push_back({bus.out_id, bus.fixed_out});
            if (int'(dut.fifo_count) > FIFO_DEPTH) check_output("fifo_bound", 64'(dut.fifo_count), 64'(FIFO_DEPTH));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] exp_fixed(input int k);
        case (k)
            0:       return 48'h3C00;
            1:       return 48'h4000;
            2:       return 48'h4200;
            default: return 48'h4400;
        endcase
    endfunction

    function automatic logic [49:0] exp_pop(input int k);
        logic [1:0] id;
        id = k[1:0];
        return {id, exp_fixed(k)};
    endfunction

    task automatic wait_pops(input int n);
        for (int c = 0; c < 60 && pop_log.size() < n; c++) tick();
        check_output("pop_count", 64'(pop_log.size()), 64'(n));
    endtask

    initial begin
        #200000;
        check_output("watchdog", 64'd0, 64'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        bus.req_i     = '0;
        bus.float_in  = {16'h4400, 16'h4200, 16'h4000, 16'h3C00};
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.req_i = 4'b1111;
        #1;
        check_output("rst_gnt", 64'(bus.gnt_o), 64'h0);
        check_output("rst_conv_valid", 64'(bus.conv_valid_o), 64'h0);
        check_output("rst_out_valid", 64'(bus.out_valid), 64'h0);
        bus.req_i = '0;
        reset = 1'b0;
        #1;
        check_output("rst_conv_float", 64'(bus.conv_float_o), 64'h0);
        check_output("rst_fixed_out", 64'(bus.fixed_out), 64'h0);
        check_output("rst_out_id", 64'(bus.out_id), 64'h0);
        tick();

        // Single request: latency from grant to out_valid is 4 cycles.
        bus.req_i = 4'b0001;
        #1;
        check_output("t1_gnt", 64'(bus.gnt_o), 64'h1);
        tick();
        bus.req_i = '0;
        check_output("t1_conv_valid", 64'(bus.conv_valid_o), 64'h1);
        check_output("t1_conv_float", 64'(bus.conv_float_o), 64'h3C00);
        tick();
        tick();
        check_output("t1_early_valid", 64'(bus.out_valid), 64'h0);
        tick();
        check_output("t1_out_valid", 64'(bus.out_valid), 64'h1);
        check_output("t1_fixed_out", 64'(bus.fixed_out), 64'h3C00);
        check_output("t1_out_id", 64'(bus.out_id), 64'h0);
        tick();
        check_output("t1_popped", 64'(bus.out_valid), 64'h0);

        // All requesting: round-robin order continues from requester 1.
        grant_log.delete();
        pop_log.delete();
        bus.req_i = 4'b1111;
        for (int c = 0; c < 60 && grant_log.size() < 8; c++) tick();
        bus.req_i = '0;
        check_output("t2_grant_count", 64'(grant_log.size()), 64'd8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
            check_output($sformatf("t2_grant%0d", i), 64'(grant_log[i]), 64'((i + 1) % 4));
        end
        wait_pops(8);
        for (int i = 0; i < 8 && i < pop_log.size(); i++) begin
            check_output($sformatf("t2_pop%0d", i), 64'(pop_log[i]), 64'(exp_pop((i + 1) % 4)));
        end
        repeat (2) tick();

        // Backpressure: credit limits to FIFO_DEPTH grants, head stays put.
        grant_log.delete();
        pop_log.delete();
        bus.out_ready = 1'b0;
        bus.req_i     = 4'b1111;
        repeat (10) tick();
        check_output("t3_grant_count", 64'(grant_log.size()), 64'd4);
        check_output("t3_gnt_blocked", 64'(bus.gnt_o), 64'h0);
        check_output("t3_out_valid", 64'(bus.out_valid), 64'h1);
        check_output("t3_head_id", 64'(bus.out_id), 64'h1);
        check_output("t3_head_data", 64'(bus.fixed_out), 64'h4000);
        check_output("t3_fifo_count", 64'(dut.fifo_count), 64'd4);
        bus.out_ready = 1'b1;
        #1;
        check_output("t3_same_cycle_credit", 64'(bus.gnt_o), 64'h0);
        tick();
        check_output("t3_resume_gnt", 64'(bus.gnt_o), 64'h2);
        tick();
        bus.req_i = '0;
        wait_pops(5);
        check_output("t3_grant_total", 64'(grant_log.size()), 64'd5);
        for (int i = 0; i < 5 && i < pop_log.size(); i++) begin
            check_output($sformatf("t3_pop%0d", i), 64'(pop_log[i]), 64'(exp_pop((i + 1) % 4)));
        end

        // Wrap-around: rr_ptr starts at 2 here.
        begin
            logic [3:0] reqs [4];
            logic [3:0] gnts [4];
            reqs = '{4'b1000, 4'b0100, 4'b1001, 4'b1001};
            gnts = '{4'b1000, 4'b0100, 4'b1000, 4'b0001};
            for (int i = 0; i < 4; i++) begin
                repeat (6) tick();
                bus.req_i = reqs[i];
                #1;
                check_output($sformatf("t4_gnt%0d", i), 64'(bus.gnt_o), 64'(gnts[i]));
                tick();
                bus.req_i = '0;
            end
        end

        // Reset with three conversions in flight.
        repeat (6) tick();
        bus.req_i = 4'b1111;
        repeat (3) tick();
        bus.req_i = '0;
        check_output("t5_inflight", 64'(bus.conv_valid_o), 64'h1);
        reset = 1'b1;
        #1;
        check_output("t5_rst_conv_valid", 64'(bus.conv_valid_o), 64'h0);
        check_output("t5_rst_conv_float", 64'(bus.conv_float_o), 64'h0);
        check_output("t5_rst_out_valid", 64'(bus.out_valid), 64'h0);
        tick();
        reset = 1'b0;
        pop_log.delete();
        repeat (8) tick();
        check_output("t5_no_stale_pops", 64'(pop_log.size()), 64'd0);
        check_output("t5_no_stale_valid", 64'(bus.out_valid), 64'h0);
        bus.req_i = 4'b1111;
        #1;
        check_output("t5_gnt_after_rst", 64'(bus.gnt_o), 64'h1);
        tick();
        bus.req_i = '0;

        // Push and pop in the same cycle with one entry queued.
        repeat (6) tick();
        bus.out_ready = 1'b0;
        bus.req_i     = 4'b0010;
        #1;
        check_output("t6_gnt_a", 64'(bus.gnt_o), 64'h2);
        tick();
        bus.req_i = 4'b0100;
        #1;
        check_output("t6_gnt_b", 64'(bus.gnt_o), 64'h4);
        tick();
        bus.req_i = '0;
        tick();
        tick();
        check_output("t6_head_a_id", 64'(bus.out_id), 64'h1);
        check_output("t6_count_before", 64'(dut.fifo_count), 64'd1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_output("t6_count_after", 64'(dut.fifo_count), 64'd1);
        check_output("t6_head_b_id", 64'(bus.out_id), 64'h2);
        check_output("t6_head_b_data", 64'(bus.fixed_out), 64'h4200);
        tick();
        bus.out_ready = 1'b1;
        tick();
        check_output("t6_drained", 64'(bus.out_valid), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
